dm_cache_subsystem: RTL and testbench

- Read-only, direct-mapped, single-clock cache subsystem.
- Contains a 32K-word backing data memory and a 1K-word cache built from 256 lines of 4 words each.
- The processor side issues word reads; misses fetch a whole 4-word block from backing memory, then respond.
- Sits between an instruction/data fetch unit and the backing store; also keeps hit/access statistics.

---
 rtl/dm_cache_if.sv | 26 ++
 rtl/dm_cache_subsystem.sv | 134 +++++++++++++
 tb/tb_dm_cache_subsystem.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_if.sv
// Processor-side bus for the direct-mapped read cache.
// The master (fetch unit) drives req/addr. The slave (cache) returns the data and statistics.
interface dm_cache_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic [CNT_W-1:0]  access_cnt;
  logic [CNT_W-1:0]  hit_cnt;

  modport master (
    output req, addr,
    input  ready, rd_valid, rd_data, hit, access_cnt, hit_cnt
  );

  modport slave (
    input  req, addr,
    output ready, rd_valid, rd_data, hit, access_cnt, hit_cnt
  );
endinterface

// File: rtl/dm_cache_subsystem.sv
// Read-only direct-mapped cache: 256 lines x 4 words, in front of a 32K-word backing ROM.
// A hit answers one cycle after acceptance. A miss stalls for MEM_LATENCY cycles
// while the block is fetched, then refills the line and answers.
module dm_cache_subsystem #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int INDEX_W     = 8,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input logic       clk,
  input logic       rst,
  dm_cache_if.slave bus
);
  localparam int OFF_W     = 2;
  localparam int WORDS     = 1 << OFF_W;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W;
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] idx;
    logic [OFF_W-1:0]   off;
  } addr_t;

  // The backing store holds word i = i at every address.
  // The block read is therefore a constant ROM whose output equals its address, zero-extended.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  state_t state, state_nxt;
  logic   accept, fill_done, lookup_hit;

  logic [NUM_LINES-1:0]          valid;
  logic [TAG_W-1:0]              tag_mem  [NUM_LINES];
  logic [WORDS-1:0][DATA_W-1:0]  data_mem [NUM_LINES];

  addr_t                         acc, miss;
  logic [LAT_W-1:0]              lat_cnt;
  logic [WORDS-1:0][DATA_W-1:0]  fill_data;

  logic              rd_valid_q, hit_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  access_cnt_q, hit_cnt_q;

  assign acc        = addr_t'(bus.addr);
  assign lookup_hit = valid[acc.idx] && (tag_mem[acc.idx] == acc.tag);

  // All four words of the missing block come back together from the backing store.
  for (genvar k = 0; k < WORDS; k++) begin : g_fill
    assign fill_data[k] = mem_word({miss.tag, miss.idx, OFF_W'(k)});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.req;
        if (accept && !lookup_hit) state_nxt = FILL;
      end
      FILL: begin
        if (lat_cnt == LAT_W'(MEM_LATENCY - 1)) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response, statistics, miss tracking and valid bits.
  // Reset clears these, so a reset during a fill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      hit_q        <= 1'b0;
      access_cnt_q <= '0;
      hit_cnt_q    <= '0;
      miss         <= '0;
      lat_cnt      <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state == FILL) lat_cnt <= lat_cnt + 1'b1;
      if (accept) begin
        access_cnt_q <= access_cnt_q + 1'b1;
        if (lookup_hit) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= data_mem[acc.idx][acc.off];
          hit_q      <= 1'b1;
          hit_cnt_q  <= hit_cnt_q + 1'b1;
        end else begin
          miss    <= acc;
          lat_cnt <= '0;
        end
      end
      if (fill_done) begin
        valid[miss.idx] <= 1'b1;
        rd_valid_q      <= 1'b1;
        rd_data_q       <= fill_data[miss.off];
        hit_q           <= 1'b0;
      end
    end
  end

  // Line storage has no reset: contents are only trusted once the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tag_mem[miss.idx]  <= miss.tag;
      data_mem[miss.idx] <= fill_data;
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.hit        = hit_q;
  assign bus.access_cnt = access_cnt_q;
  assign bus.hit_cnt    = hit_cnt_q;
endmodule

// File: tb/tb_dm_cache_subsystem.sv
// Directed bench for dm_cache_subsystem.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_dm_cache_subsystem;
  localparam int ADDR_W = 15, DATA_W = 32, INDEX_W = 8, MEM_LATENCY = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dm_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dm_cache_subsystem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W),
    .MEM_LATENCY(MEM_LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Hold reset for two edges; leaves the bench on a falling edge with rst low.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b0;
    bus.addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one read and hold it until accepted, then wait for its response.
  // lat counts cycles from acceptance to rd_valid; low counts cycles with ready low in between.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output logic h, output int lat, output int low);
    int n;
    @(negedge clk);
    bus.req = 1'b1;
    bus.addr = a;
    n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 0;
    low = 0;
    d = 'x;
    h = 1'bx;
    do begin
      @(negedge clk);
      bus.req = 1'b0;
      lat++;
      if (!bus.ready) low++;
    end while (!bus.rd_valid && lat < 50);
    checks++;
    if (!bus.rd_valid) begin
      errors++;
      $display("FAIL timeout addr=%0d got no rd_valid within %0d cycles", a, lat);
    end else begin
      d = bus.rd_data;
      h = bus.hit;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    // A request presented while rst is high must not be accepted.
    @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b1;
    bus.addr = 15'd5;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rd_valid=%b rd_data=%0d hit=%b expected 1 0 0 0",
               bus.ready, bus.rd_valid, bus.rd_data, bus.hit);
    end
    checks++;
    if (bus.access_cnt !== 16'd0 || bus.hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters access=%0d hit=%0d expected 0 0", bus.access_cnt, bus.hit_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.access_cnt !== 16'd0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL req_during_rst rd_valid=%b access=%0d ready=%b expected 0 0 1",
               bus.rd_valid, bus.access_cnt, bus.ready);
    end
  endtask

  task automatic test_cold_sequence();
    logic [ADDR_W-1:0] addrs [7] = '{24, 25, 26, 27, 28, 24, 29};
    logic              hits  [7] = '{0, 1, 1, 1, 0, 1, 1};
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      do_read(addrs[i], d, h, lat, low);
      checks++;
      if (d !== DATA_W'(addrs[i]) || h !== hits[i]) begin
        errors++;
        $display("FAIL cold[%0d] data=%0d hit=%b expected %0d %b", i, d, h, addrs[i], hits[i]);
      end
    end
    checks++;
    if (bus.access_cnt !== 16'd7 || bus.hit_cnt !== 16'd5) begin
      errors++;
      $display("FAIL cold_counters access=%0d hit=%0d expected 7 5", bus.access_cnt, bus.hit_cnt);
    end
  endtask

  task automatic test_miss_timing();
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    apply_reset();
    do_read(15'd100, d, h, lat, low);
    checks++;
    if (lat != 3 || low != 2 || d !== 32'd100 || h !== 1'b0) begin
      errors++;
      $display("FAIL miss_timing lat=%0d ready_low=%0d data=%0d hit=%b expected 3 2 100 0",
               lat, low, d, h);
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL miss_ready_return ready=%b expected 1", bus.ready);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd100 || bus.hit !== 1'b0) begin
      errors++;
      $display("FAIL miss_pulse rd_valid=%b data=%0d hit=%b expected 0 100 0",
               bus.rd_valid, bus.rd_data, bus.hit);
    end
  endtask

  task automatic test_conflict();
    logic [ADDR_W-1:0] addrs [3] = '{24, 1048, 24};
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, h, lat, low);
      checks++;
      if (d !== DATA_W'(addrs[i]) || h !== 1'b0 || lat != 3) begin
        errors++;
        $display("FAIL conflict[%0d] data=%0d hit=%b lat=%0d expected %0d 0 3",
                 i, d, h, lat, addrs[i]);
      end
    end
    checks++;
    if (bus.hit_cnt !== 16'd0 || bus.access_cnt !== 16'd3) begin
      errors++;
      $display("FAIL conflict_counters access=%0d hit=%0d expected 3 0", bus.access_cnt, bus.hit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4] = '{33, 34, 35, 32};
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    apply_reset();
    do_read(15'd32, d, h, lat, low);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== DATA_W'(addrs[i-1]) || bus.hit !== 1'b1) begin
          errors++;
          $display("FAIL b2b[%0d] rd_valid=%b data=%0d hit=%b expected 1 %0d 1",
                   i - 1, bus.rd_valid, bus.rd_data, bus.hit, addrs[i-1]);
        end
      end
      if (i < 4) begin
        bus.req = 1'b1;
        bus.addr = addrs[i];
      end else begin
        bus.req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.access_cnt !== 16'd5 || bus.hit_cnt !== 16'd4) begin
      errors++;
      $display("FAIL b2b_end rd_valid=%b access=%0d hit=%0d expected 0 5 4",
               bus.rd_valid, bus.access_cnt, bus.hit_cnt);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    int                seen;
    apply_reset();
    @(negedge clk);
    bus.req = 1'b1;
    bus.addr = 15'd200;
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL midfill_in_fill ready=%b expected 0", bus.ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rd_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || bus.access_cnt !== 16'd0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL midfill_abandon responses=%0d access=%0d ready=%b expected 0 0 1",
               seen, bus.access_cnt, bus.ready);
    end
    do_read(15'd200, d, h, lat, low);
    checks++;
    if (d !== 32'd200 || h !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL midfill_retry data=%0d hit=%b lat=%0d expected 200 0 3", d, h, lat);
    end
    checks++;
    if (bus.access_cnt !== 16'd1 || bus.hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midfill_counters access=%0d hit=%0d expected 1 0", bus.access_cnt, bus.hit_cnt);
    end
  endtask

  task automatic test_top_of_memory();
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat, low;
    apply_reset();
    do_read(15'd32767, d, h, lat, low);
    checks++;
    if (d !== 32'd32767 || h !== 1'b0) begin
      errors++;
      $display("FAIL top_miss data=%0d hit=%b expected 32767 0", d, h);
    end
    do_read(15'd32764, d, h, lat, low);
    checks++;
    if (d !== 32'd32764 || h !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL top_hit data=%0d hit=%b lat=%0d expected 32764 1 1", d, h, lat);
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.addr = '0;
    test_reset();
    test_cold_sequence();
    test_miss_timing();
    test_conflict();
    test_back_to_back();
    test_reset_mid_fill();
    test_top_of_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
